data_memory_ctrl: RTL
=====================

Name: data_memory_ctrl

Overview:
Parametrised data memory for the 16-bit RISC core. It adds the following:
- valid/ready request handshake
- configurable wait-state latency
- byte-lane write enables
- out-of-range error response
- post-reset zero-clear sequence

It sits between the core's memory stage and the data store. It holds one outstanding transaction at a time.

Parameters:
DATA_W, 16, word width in bits; multiple of 8
ADDR_W, 16, request address width (word address)
DEPTH, 256, number of words; addresses >= DEPTH are out of range
WAIT_STATES, 0, extra cycles between accept and response (0..15)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  request accepted this cycle when req_valid && req_ready
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  word address
req_wdata  input  DATA_W  write data
req_be  input  DATA_W/8  byte-lane write enables; bit i covers bits [8i+7:8i]
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  DATA_W  read data; 0 for writes and for errors
rsp_err  output  1  valid with rsp_valid; 1 = out-of-range (or parity, see option)
init_done  output  1  high once the clear sequence completes

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0. The FSM enters CLEAR with clear index 0.
- CLEAR state:
  - Writes 0 to word[idx] each cycle, idx = 0..DEPTH-1, taking DEPTH cycles.
  - Then init_done=1 (held until next rst) and the FSM goes to IDLE.
  - req_ready=0 throughout.
- IDLE state: req_ready=1. On accept:
  - In-range write: lanes with req_be[i]=1 are updated at the accept edge; other lanes are unchanged. req_be=0 is a legal no-op.
  - In-range read: the word is sampled into the response register at the accept edge. req_be is ignored.
  - Out of range: no write; response carries rdata=0, err=1.
  - Next state: WAIT if WAIT_STATES>0, else RESP.
- WAIT state: a counter loaded with WAIT_STATES-1 decrements each cycle; at 0 the FSM goes to RESP. req_ready=0.
- RESP state: rsp_valid=1 for exactly one cycle, then IDLE. req_ready=0.
- Latency: response arrives WAIT_STATES+1 cycles after the accept edge. Throughput is one transaction per WAIT_STATES+2 cycles.
- rsp_rdata and rsp_err are held from RESP until the next response; they are don't-care when rsp_valid=0.
- Address compare uses the full ADDR_W bits; there is no wrap or aliasing.
- rst mid-operation: any pending response is dropped with no rsp_valid. A write already accepted stays committed, but the following CLEAR zeroes the whole array.
- req_valid during CLEAR, WAIT or RESP is ignored and not queued.

Optional Feature:
DMEM_PARITY_EN
- Defined:
  - One even-parity bit is stored per byte lane and written with the lane.
  - CLEAR writes parity 0.
  - On read, any lane mismatch sets rsp_err=1; rsp_rdata is still returned.
  - Adds input port par_inject (1 bit). When set on an accepted write, it inverts the stored parity of every enabled lane.
- Undefined: no parity storage and no par_inject port. rsp_err reflects out-of-range only.

Decomposition:
- Shared package dmem_pkg holds:
  - FSM state enum (CLEAR, IDLE, WAIT, RESP)
  - BE_W = DATA_W/8
  - wait-counter width constant (4)
- One sub-module, dmem_array: single-port synchronous-write storage with per-lane enables and combinational read. The controller FSM wraps it.

Test Plan:
1. Assert rst for 2 cycles, release -> init_done rises exactly DEPTH cycles later (256); req_ready stays 0 until then; every word reads back 16'h0000.
2. WAIT_STATES=0: write 16'hBEEF to addr 5 with be=2'b11, then read addr 5 -> rsp_valid exactly 1 cycle after each accept; read returns 16'hBEEF with err=0.
3. Byte lanes: after test 2, write 16'h1234 with be=2'b01 to addr 5 -> read returns 16'hBE34; a write with be=2'b00 leaves it 16'hBE34.
4. Out of range: read addr 16'h0100 with DEPTH=256 -> rsp_err=1, rsp_rdata=0. A write to 16'hFFFF leaves words 0..255 unchanged.
5. WAIT_STATES=3: accept a read -> rsp_valid 4 cycles later; req_ready=0 for 4 cycles after accept; a second req_valid during this window gets no response.
6. DMEM_PARITY_EN: write 16'hA5A5 to addr 7 with par_inject=1 -> read gives rdata=16'hA5A5, err=1. Rewrite with par_inject=0 -> err=0. Also assert rst during WAIT -> no rsp_valid, and CLEAR restarts.

Source files
------------

// File: rtl/dmem_pkg.sv
//------------------------------------------------------------------------------
// Module : dmem_pkg
// Desc   : Shared types and constants for the data memory controller.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package dmem_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } dmem_state_t;

    localparam int DATA_W_DEF = 16;
    localparam int BE_W       = DATA_W_DEF / 8;
    localparam int WCNT_W     = 4;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
//------------------------------------------------------------------------------
// Module : dmem_array
// Desc   : Single-port storage, per-byte-lane synchronous write, combinational
//          read. Optional per-lane parity bit when DMEM_PARITY_EN is defined.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dmem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8,
    parameter int LANES  = DATA_W / 8
) (
    input  logic              clk,
    input  logic [IDX_W-1:0]  addr,
    input  logic [LANES-1:0]  lane_we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
`ifdef DMEM_PARITY_EN
    ,
    input  logic [LANES-1:0]  par_wdata,
    output logic [LANES-1:0]  par_rdata
`endif
);

    // One memory per lane keeps every storage element single-driver.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [7:0] r_lane [DEPTH];

        always_ff @(posedge clk) begin
            if (lane_we[g]) begin
                r_lane[addr] <= wdata[8*g +: 8];
            end
        end

        assign rdata[8*g +: 8] = r_lane[addr];

`ifdef DMEM_PARITY_EN
        logic r_par [DEPTH];

        always_ff @(posedge clk) begin
            if (lane_we[g]) begin
                r_par[addr] <= par_wdata[g];
            end
        end

        assign par_rdata[g] = r_par[addr];
`endif
    end

endmodule

`default_nettype wire

// File: rtl/data_memory_ctrl.sv
//------------------------------------------------------------------------------
// Module : data_memory_ctrl
// Desc   : Data memory with valid/ready handshake, wait states, byte lanes,
//          range error and post-reset clear. Option macro: DMEM_PARITY_EN.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
`ifdef DMEM_PARITY_EN
    input  logic                  par_inject,
`endif
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  init_done
);

    localparam int LANES = be_width(DATA_W);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LOAD =
        (WAIT_STATES > 0) ? WCNT_W'(WAIT_STATES - 1) : '0;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

    dmem_state_t       r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [WCNT_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_pend_rdata;
    logic              r_pend_err;

    logic              w_clear;
    logic              w_accept;
    logic              w_in_range;
    logic [IDX_W-1:0]  w_addr;
    logic [LANES-1:0]  w_lane_we;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata;
    logic              w_par_err;
    logic [DATA_W-1:0] w_rsp_rdata;
    logic              w_rsp_err;

    assign w_clear    = (r_state == ST_CLEAR);
    assign w_accept   = req_valid && req_ready;
    assign w_in_range = ({1'b0, req_addr} < DEPTH_EXT);
    assign w_addr     = w_clear ? r_idx : req_addr[IDX_W-1:0];
    assign w_wdata    = w_clear ? '0 : req_wdata;
    assign w_lane_we  = w_clear ? '1 :
                        (w_accept && req_we && w_in_range) ? req_be : '0;

`ifdef DMEM_PARITY_EN
    logic [LANES-1:0] w_par_wdata;
    logic [LANES-1:0] w_par_rdata;
    logic [LANES-1:0] w_par_bad;

    for (genvar g = 0; g < LANES; g++) begin : g_par
        assign w_par_wdata[g] = w_clear ? 1'b0 : (^req_wdata[8*g +: 8]) ^ par_inject;
        assign w_par_bad[g]   = (^w_rdata[8*g +: 8]) ^ w_par_rdata[g];
    end

    assign w_par_err = |w_par_bad;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .LANES  (LANES)
    ) u_array (
        .clk       (clk),
        .addr      (w_addr),
        .lane_we   (w_lane_we),
        .wdata     (w_wdata),
        .rdata     (w_rdata),
        .par_wdata (w_par_wdata),
        .par_rdata (w_par_rdata)
    );
`else
    assign w_par_err = 1'b0;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .LANES  (LANES)
    ) u_array (
        .clk     (clk),
        .addr    (w_addr),
        .lane_we (w_lane_we),
        .wdata   (w_wdata),
        .rdata   (w_rdata)
    );
`endif

    assign w_rsp_rdata = (w_in_range && !req_we) ? w_rdata : '0;
    assign w_rsp_err   = !w_in_range || (!req_we && w_par_err);

    // Response fields are captured at the accept edge; with wait states they
    // park in r_pend_* so the previous response stays visible meanwhile.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_CLEAR;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_pend_rdata <= '0;
            r_pend_err   <= 1'b0;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            init_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_idx == IDX_W'(DEPTH - 1)) begin
                        r_state   <= ST_IDLE;
                        init_done <= 1'b1;
                        req_ready <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (w_accept) begin
                        req_ready <= 1'b0;
                        if (WAIT_STATES > 0) begin
                            r_state      <= ST_WAIT;
                            r_cnt        <= WAIT_LOAD;
                            r_pend_rdata <= w_rsp_rdata;
                            r_pend_err   <= w_rsp_err;
                        end else begin
                            r_state   <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= w_rsp_rdata;
                            rsp_err   <= w_rsp_err;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state   <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= r_pend_rdata;
                        rsp_err   <= r_pend_err;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    r_state   <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: r_state <= ST_CLEAR;
            endcase
        end
    end

endmodule

`default_nettype wire
